// File: rtl/wb_arbiter.sv
// Writeback arbiter: collects functional-unit results over valid/ready,
// picks one per cycle by round-robin and drives the registered one-hot
// write strobe plus shared data bus feeding every register cell. The strobe
// is also what releases a cell's write reservation.
module wb_arbiter #(
  parameter int REG_LEN   = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_IDX_W = 5,
  parameter int NUM_SRC   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid_i,
  output logic [NUM_SRC-1:0]           src_ready_o,
  input  logic [NUM_SRC*REG_IDX_W-1:0] src_idx_i,
  input  logic [NUM_SRC*REG_LEN-1:0]   src_data_i,
  input  logic                         stall_i,
  output logic [NUM_REGS-1:0]          wb_o,
  output logic [REG_LEN-1:0]           wb_data_o,
  output logic [REG_IDX_W-1:0]         wb_idx_o,
  output logic                         wb_drop_o
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]     ptr;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   upper_req;
  logic [NUM_SRC-1:0]   grant;
  logic [PTR_W-1:0]     grant_k;
  logic                 transfer;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [REG_LEN-1:0]   sel_data;
  logic                 sel_in_range;
  logic [NUM_REGS-1:0]  sel_onehot;

  // Round-robin pick: prefer the lowest requester at or above ptr, otherwise
  // wrap around to the lowest requester overall.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    req       = stall_i ? '0 : src_valid_i;
    upper_req = '0;
    grant     = '0;
    grant_k   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      upper_req[i] = req[i] && (i >= int'(ptr));
    end
    if (|upper_req) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (upper_req[i]) grant_k = PTR_W'(i);
      end
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (req[i]) grant_k = PTR_W'(i);
      end
    end
    if (|req) grant[grant_k] = 1'b1;
  end

  assign src_ready_o = rst ? grant : '0;
  assign transfer    = |grant;

  // Select the granted source's index and data, then decode the strobe.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_idx  = src_idx_i[i*REG_IDX_W +: REG_IDX_W];
        sel_data = src_data_i[i*REG_LEN +: REG_LEN];
      end
    end
    // Full-width index compare: out-of-range indices never alias a cell.
    sel_in_range = (32'(sel_idx) < NUM_REGS);
    sel_onehot   = sel_in_range ? (NUM_REGS'(1) << sel_idx) : '0;
  end

  // Round-robin pointer: moves just past the source that transferred.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (grant_k == PTR_W'(NUM_SRC - 1)) ? '0 : grant_k + 1'b1;
    end
  end

  // Registered writeback: strobe/drop pulse per transfer, index and data hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_o      <= '0;
      wb_data_o <= '0;
      wb_idx_o  <= '0;
      wb_drop_o <= 1'b0;
    end else if (transfer) begin
      wb_o      <= sel_onehot;
      wb_data_o <= sel_data;
      wb_idx_o  <= sel_idx;
      wb_drop_o <= !sel_in_range;
    end else begin
      wb_o      <= '0;
      wb_drop_o <= 1'b0;
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register cells.
- Collects results from NUM_SRC functional units over valid/ready handshakes and picks one per cycle by round-robin.
- Drives the one-hot per-register write strobe and the shared data bus that feed every cell's wb_i and data_i.
- Also asserting wb_i releases that cell's write reservation, so this block is the sole path that clears reservations.

Parameters:
REG_LEN, 32, data width of each register and of every source result
NUM_REGS, 32, number of register cells driven; width of the strobe vector
REG_IDX_W, 5, width of a destination register index
NUM_SRC, 4, number of functional-unit result sources (>=2)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low
src_valid_i  input  NUM_SRC  per-source result valid
src_ready_o  output  NUM_SRC  per-source accept; at most one bit set
src_idx_i  input  NUM_SRC*REG_IDX_W  flattened destination indices; source k occupies bits [k*REG_IDX_W +: REG_IDX_W]
src_data_i  input  NUM_SRC*REG_LEN  flattened result data; source k occupies [k*REG_LEN +: REG_LEN]
stall_i  input  1  when high no source is granted
wb_o  output  NUM_REGS  registered one-hot write strobe; bit r drives cell r wb_i
wb_data_o  output  REG_LEN  registered write data; broadcast to all cells' data_i
wb_idx_o  output  REG_IDX_W  registered index of the current write
wb_drop_o  output  1  registered one-cycle pulse: accepted result had index >= NUM_REGS

Behaviour:
- Reset (rst low, asynchronous): wb_o=0, wb_data_o=0, wb_idx_o=0, wb_drop_o=0, round-robin pointer ptr=0. src_ready_o=0 while rst is low.
- Grant (combinational):
  - Let req = src_valid_i masked to 0 when stall_i=1.
  - Grant goes to the first set bit of req, searching ptr, ptr+1, …, wrapping modulo NUM_SRC.
  - src_ready_o = one-hot grant, or 0 if req=0.
  - src_ready_o may depend on src_valid_i; sources must not make valid depend on ready.
- Transfer: occurs for source k when src_valid_i[k] & src_ready_o[k] at a rising edge.
- Source rule: a source holding valid keeps idx/data stable until its transfer. Dropping valid before transfer is illegal; behaviour is unspecified.
- Pointer: on a transfer from source k, ptr <= (k+1) mod NUM_SRC. With no transfer, ptr holds.
- Latency: exactly 1 cycle. At the edge that completes a transfer with index i:
  - If i < NUM_REGS: wb_o <= one-hot(i), wb_idx_o <= i, wb_data_o <= data, wb_drop_o <= 0.
  - If i >= NUM_REGS: wb_o <= 0, wb_idx_o <= i, wb_data_o <= data, wb_drop_o <= 1.
- No transfer in a cycle: wb_o <= 0, wb_drop_o <= 0; wb_data_o and wb_idx_o hold their last values.
- Throughput: one result per cycle sustained; back-to-back transfers produce back-to-back strobes.
- Same-destination conflict: two sources targeting the same index in one cycle are serialised by round-robin order. Writes land in grant order; last granted wins in the cell.
- Starvation: any source holding valid is granted within NUM_SRC cycles in which stall_i=0.
- stall_i: takes effect in the same cycle (ready forced 0). Outputs for the following cycle follow the no-transfer rule. A result registered before the stall still appears.
- Reset mid-operation: outputs clear immediately and asynchronously; an in-flight strobe is lost. Sources keep valid and are re-arbitrated from ptr=0 after release.
- Width rule: NUM_REGS <= 2**REG_IDX_W. The one-hot decode compares the full REG_IDX_W index; no truncation.

Test Plan:
- Reset release, all valid=0 for 5 cycles -> wb_o=0, wb_data_o=0, wb_drop_o=0, src_ready_o=0 every cycle.
- Source 2 valid, idx=7, data=0xDEADBEEF, single cycle -> src_ready_o=4'b0100 that cycle. Next cycle: wb_o=1<<7, wb_idx_o=7, wb_data_o=0xDEADBEEF. Cycle after: wb_o=0, data holds 0xDEADBEEF.
- All 4 sources valid continuously, ptr=0, distinct idx 1..4 -> grants 0,1,2,3,0,… on consecutive cycles; wb_o sequence 1<<1,1<<2,1<<3,1<<4 with no gaps.
- Sources 0 and 3 both idx=5 with data 0x11/0x33, ptr=3 -> source 3 granted first, then 0. Strobes for r5 on two consecutive cycles carry 0x33 then 0x11.
- stall_i=1 for 3 cycles with source 1 valid -> src_ready_o=0 and wb_o=0 throughout. First cycle after stall_i=0: ready[1]=1, strobe the following cycle.
- With NUM_REGS=24, idx=30, data=0x5A -> wb_o=0, wb_drop_o=1 for exactly one cycle, wb_idx_o=30. Then assert rst mid-stream -> all outputs 0 immediately, ptr restarts at 0.
